mux_4to1_rr_arbiter: RTL and testbench
======================================

// Module: mux_4to1_rr_arbiter
// PURPOSE
//   Round-robin arbiter that shares one 4:1 single-bit mux datapath between four requesters.
//   Each requester raises req[i] and holds it for as long as it needs the datapath; the block
//   grants exactly one owner and drives the mux select so that dout carries the owner's din bit.
//   Sits between the requester logic and the shared serial output path.
// PARAMETERS
//   MAX_HOLD   8   cycles an owner may keep the grant while others wait (ARB_BURST_LIMIT_EN only); >=2
//   RESET_PTR  3   last-owner pointer value after reset; default 3 gives requester 0 first priority
// PORTS
//   clk    input   1  single clock; all state updates on its rising edge
//   rst_n  input   1  asynchronous, active-low reset
//   req    input   4  per-requester request; level, held for the whole transfer
//   din    input   4  per-requester data bit; din[i] belongs to requester i
//   gnt    output  4  one-hot grant, registered; 4'b0000 when idle
//   sel    output  2  registered mux select = index of owner; holds last owner when idle
//   busy   output  1  registered; 1 while any grant is active (== |gnt)
//   dout   output  1  din[sel] gated by busy; 0 when idle (combinational from din)
// BEHAVIOUR
//   - Reset (rst_n=0, async): gnt=0, busy=0, sel=0, dout=0, state=IDLE, last_ptr=RESET_PTR, hold_cnt=0.
//   - FSM states: IDLE, GRANT.
//   - IDLE: when |req, pick winner = first i with req[i]=1, scanning last_ptr+1, +2, +3, +4 (mod 4).
//     Next cycle: gnt=onehot(winner), sel=winner, busy=1, state=GRANT. Latency req->gnt = 1 cycle.
//   - GRANT: owner keeps the grant while req[sel]=1. When req[sel]=0: last_ptr<=sel; if any other req is
//     set, grant the RR winner on the next cycle (back-to-back, no idle cycle). Otherwise gnt=0, busy=0,
//     state=IDLE.
//   - Grant changes only at clock edges; gnt is never multi-hot and never names a requester whose req
//     was 0 in the deciding cycle.
//   - Simultaneous requests are resolved solely by the RR scan. Requests that arrive while a grant is
//     held are evaluated at the next decision point.
//   - The owner dropping req and re-raising it in the same cycle as another requester is scanned last.
//   - Reset asserted mid-grant: outputs clear immediately, without waiting for a clock edge.
//   - dout = busy & din[sel]; no added latency on the data path.
// CONFIGURATION
//   - `define ARB_BURST_LIMIT_EN: hold_cnt counts GRANT cycles of the current owner and resets on every
//     new grant. When hold_cnt==MAX_HOLD-1 and any req[j] with j!=sel is set, the grant is revoked.
//     Next cycle: the RR winner among the others is granted, last_ptr<=old owner, and the old owner must
//     re-arbitrate. With no other requester pending, the grant is kept and hold_cnt saturates.
//   - Macro absent: no hold_cnt logic and no revocation; the owner keeps the grant until it drops req.
// STRUCTURE
//   - Shared package mux_arb_pkg: NUM_REQ=4, SEL_W=2, state enum {IDLE, GRANT}, and the
//     rr_pick(req, ptr) function that returns the winner index and a found flag.
//   - Sub-module: datapath instance of the existing mux_4to1_structural (in=din, sel=sel); its output
//     is ANDed with busy to form dout.
//   - FSM, last_ptr and hold_cnt live in this module.
// TESTING
//   1. Reset mid-grant: owner 2 active, pull rst_n low between edges -> gnt=0, busy=0, sel=0, dout=0
//      immediately.
//   2. Single request: req=4'b0010 at cycle 0 -> cycle 1 gnt=4'b0010, sel=1; toggle din[1] -> dout
//      follows the same cycle; din[0,2,3] are ignored.
//   3. Fairness: from reset, req=4'b1111, each owner drops req after 2 cycles -> grant order 0,1,2,3,
//      back-to-back, busy never drops.
//   4. Handover: owner 2 active, req[0]=1; drop req[2] -> next cycle gnt=4'b0001; drop req[0] with no
//      others -> gnt=0, busy=0.
//   5. ARB_BURST_LIMIT_EN with MAX_HOLD=4: req[0] held, req[1] raised -> gnt[0] for 4 cycles, then
//      gnt=4'b0010. Without the macro, gnt[0] holds for 100 or more cycles.
//   6. ARB_BURST_LIMIT_EN, lone owner: req=4'b1000 held for 20 cycles -> gnt=4'b1000 throughout, with
//      no revoke.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared sizes, FSM states and round-robin pick helper for the 4:1 mux arbiter.
package mux_arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int SEL_W = 2;
  typedef enum logic {IDLE, GRANT} state_t;
  typedef struct packed {
    logic found;
    logic [SEL_W-1:0] idx;
  } pick_t;
  // Scan ptr+1 .. ptr+4; walking downwards lets the closest requester overwrite the rest.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req, input logic [SEL_W-1:0] ptr);
    pick_t p;
    logic [SEL_W-1:0] i;
    p = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      i = ptr + SEL_W'(k);
      if (req[i]) begin
        p.found = 1'b1;
        p.idx = i;
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/mux_4to1_structural.sv
// mux_4to1_structural: single-bit 4:1 mux built from two levels of 2:1 selection.
module mux_4to1_structural (
  input  logic [3:0] in,
  input  logic [1:0] sel,
  output logic       out
);
  logic lo, hi;
  assign lo = sel[0] ? in[1] : in[0];
  assign hi = sel[0] ? in[3] : in[2];
  assign out = sel[1] ? hi : lo;
endmodule

// File: rtl/mux_4to1_rr_arbiter.sv
// mux_4to1_rr_arbiter: round-robin owner of a shared 4:1 single-bit mux.
// Optional ARB_BURST_LIMIT_EN revokes a grant held MAX_HOLD cycles while others wait.
module mux_4to1_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int               MAX_HOLD  = 8,
  parameter logic [SEL_W-1:0] RESET_PTR = 2'd3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] din,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               dout
);
  state_t state, state_nx;
  logic [SEL_W-1:0] sel_nx, last_ptr, last_nx;
  logic [NUM_REQ-1:0] others;
  pick_t pick;
  logic mux_out;
`ifdef ARB_BURST_LIMIT_EN
  localparam int HW = $clog2(MAX_HOLD);
  logic [HW-1:0] hold_cnt, hold_nx;
  logic at_limit;
  assign at_limit = hold_cnt == HW'(MAX_HOLD - 1);
`endif
  assign others = req & ~(NUM_REQ'(1) << sel);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel <= '0;
      last_ptr <= RESET_PTR;
`ifdef ARB_BURST_LIMIT_EN
      hold_cnt <= '0;
`endif
    end else begin
      state <= state_nx;
      sel <= sel_nx;
      last_ptr <= last_nx;
`ifdef ARB_BURST_LIMIT_EN
      hold_cnt <= hold_nx;
`endif
    end
  end
  always_comb begin
    state_nx = state;
    sel_nx = sel;
    last_nx = last_ptr;
    pick = rr_pick(req, last_ptr);
`ifdef ARB_BURST_LIMIT_EN
    hold_nx = at_limit ? hold_cnt : hold_cnt + HW'(1);
`endif
    if (state == IDLE) begin
      if (pick.found) begin
        state_nx = GRANT;
        sel_nx = pick.idx;
`ifdef ARB_BURST_LIMIT_EN
        hold_nx = '0;
`endif
      end
    end else if (!req[sel]) begin
      // Pointer moves to the departing owner so it is scanned last.
      last_nx = sel;
      pick = rr_pick(req, sel);
      state_nx = pick.found ? GRANT : IDLE;
      sel_nx = pick.found ? pick.idx : sel;
`ifdef ARB_BURST_LIMIT_EN
      hold_nx = '0;
`endif
    end
`ifdef ARB_BURST_LIMIT_EN
    else if (at_limit && |others) begin
      last_nx = sel;
      pick = rr_pick(others, sel);
      sel_nx = pick.idx;
      hold_nx = '0;
    end
`endif
  end
  assign busy = state == GRANT;
  assign gnt = busy ? NUM_REQ'(1) << sel : '0;
  mux_4to1_structural u_mux (.in(din), .sel(sel), .out(mux_out));
  assign dout = busy & mux_out;
endmodule

// File: tb/tb_mux_4to1_rr_arbiter.sv
// tb_mux_4to1_rr_arbiter: scoreboard bench; a cycle model queues expected outputs per clock.
module tb_mux_4to1_rr_arbiter;
  localparam int MH = 4;
  logic clk = 0, rst_n = 0;
  logic [3:0] req = '0, din = '0, gnt;
  logic [1:0] sel;
  logic busy, dout;
  int checks = 0, failures = 0;
  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic busy;
  } exp_t;
  exp_t sbq[$];
  logic m_busy;
  logic [1:0] m_owner, m_last;
  int m_hold;

  mux_4to1_rr_arbiter #(.MAX_HOLD(MH), .RESET_PTR(2'd3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .gnt(gnt), .sel(sel), .busy(busy), .dout(dout)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] scan(input logic [3:0] r, input logic [1:0] p);
    for (int k = 1; k <= 4; k++) begin
      logic [1:0] i;
      i = 2'(int'(p) + k);
      if (r[i]) return {1'b1, i};
    end
    return 3'b000;
  endfunction

  task automatic model_reset();
    m_busy = 0;
    m_owner = 0;
    m_last = 3;
    m_hold = 0;
    sbq.delete();
  endtask

  task automatic model_step();
    logic [2:0] w;
    logic [3:0] oth;
    oth = req & ~(4'b0001 << m_owner);
    if (!m_busy) begin
      w = scan(req, m_last);
      if (w[2]) begin
        m_busy = 1;
        m_owner = w[1:0];
        m_hold = 0;
      end
    end else if (!req[m_owner]) begin
      m_last = m_owner;
      w = scan(req, m_last);
      if (w[2]) begin
        m_owner = w[1:0];
        m_hold = 0;
      end else m_busy = 0;
    end
`ifdef ARB_BURST_LIMIT_EN
    else if (m_hold == MH - 1 && oth != 0) begin
      m_last = m_owner;
      w = scan(oth, m_owner);
      m_owner = w[1:0];
      m_hold = 0;
    end else if (m_hold < MH - 1) m_hold++;
`endif
  endtask

  task automatic cycle();
    exp_t e, a;
    model_step();
    sbq.push_back({m_busy ? (4'b0001 << m_owner) : 4'b0000, m_owner, m_busy});
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    a = {gnt, sel, busy};
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL cycle gnt/sel/busy got=%b/%0d/%b exp=%b/%0d/%b t=%0t", a.gnt, a.sel, a.busy, e.gnt, e.sel, e.busy, $time);
    end
    checks++;
    if (dout !== (e.busy & din[e.sel])) begin
      failures++;
      $display("FAIL cycle_dout got=%b exp=%b t=%0t", dout, e.busy & din[e.sel], $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    req = '0;
    din = '0;
    #7;
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    din = 4'b1111;
    #2;
    checks++;
    if ({gnt, sel, busy, dout} !== 8'b0) begin
      failures++;
      $display("FAIL reset gnt/sel/busy/dout got=%b/%0d/%b/%b exp=0/0/0/0", gnt, sel, busy, dout);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b0100;
    din = 4'b1111;
    cycle();
    cycle();
    #3;
    rst_n = 0;
    #1;
    checks++;
    if ({gnt, sel, busy, dout} !== 8'b0) begin
      failures++;
      $display("FAIL reset_mid_grant gnt/sel/busy/dout got=%b/%0d/%b/%b exp=0/0/0/0", gnt, sel, busy, dout);
    end
    req = '0;
    @(negedge clk);
    rst_n = 1;
    model_reset();
    cycle();
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0010;
    cycle();
    checks++;
    if (gnt !== 4'b0010 || sel !== 2'd1) begin
      failures++;
      $display("FAIL single_grant gnt/sel got=%b/%0d exp=0010/1", gnt, sel);
    end
    din = 4'b1101;
    #1;
    checks++;
    if (dout !== 1'b0) begin
      failures++;
      $display("FAIL single_dout_lo got=%b exp=0", dout);
    end
    din = 4'b0010;
    #1;
    checks++;
    if (dout !== 1'b1) begin
      failures++;
      $display("FAIL single_dout_hi got=%b exp=1", dout);
    end
    req = '0;
    cycle();
  endtask

  task automatic test_fairness();
    int held, last_seen, gaps;
    logic [1:0] seen[$];
    do_reset();
    req = 4'b1111;
    held = 0;
    last_seen = -1;
    gaps = 0;
    for (int c = 0; c < 30 && (req != 0 || m_busy); c++) begin
      if (m_busy && held >= 2) req[m_owner] = 0;
      cycle();
      if (m_busy) begin
        held = (int'(m_owner) == last_seen) ? held + 1 : 1;
        last_seen = int'(m_owner);
      end
      if (busy && (seen.size() == 0 || seen[$] != sel)) seen.push_back(sel);
      if (seen.size() > 0 && seen.size() < 4 && !busy) gaps++;
    end
    checks++;
    if (seen.size() != 4) begin
      failures++;
      $display("FAIL fair_count got=%0d exp=4", seen.size());
    end else for (int i = 0; i < 4; i++) begin
      checks++;
      if (seen[i] !== 2'(i)) begin
        failures++;
        $display("FAIL fair_order[%0d] got=%0d exp=%0d", i, seen[i], i);
      end
    end
    checks++;
    if (gaps != 0) begin
      failures++;
      $display("FAIL fair_busy_gaps got=%0d exp=0", gaps);
    end
  endtask

  task automatic test_handover();
    do_reset();
    req = 4'b0100;
    cycle();
    req = 4'b0101;
    cycle();
    req = 4'b0001;
    cycle();
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL handover gnt got=%b exp=0001", gnt);
    end
    req = 4'b0000;
    cycle();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL handover_idle gnt/busy got=%b/%b exp=0000/0", gnt, busy);
    end
  endtask

  task automatic test_burst();
    int n0, left, runs;
    logic [3:0] after;
    do_reset();
    req = 4'b0001;
    cycle();
    req = 4'b0011;
    n0 = 1;
    left = 0;
    after = '0;
`ifdef ARB_BURST_LIMIT_EN
    runs = 8;
`else
    runs = 110;
`endif
    for (int c = 0; c < runs; c++) begin
      cycle();
      if (!left && gnt === 4'b0001) n0++;
      else if (!left) begin
        left = 1;
        after = gnt;
      end
    end
`ifdef ARB_BURST_LIMIT_EN
    checks++;
    if (n0 != MH || after !== 4'b0010) begin
      failures++;
      $display("FAIL burst_revoke held/next got=%0d/%b exp=%0d/0010", n0, after, MH);
    end
`else
    checks++;
    if (n0 < 100) begin
      failures++;
      $display("FAIL burst_hold got=%0d exp>=100", n0);
    end
`endif
    req = '0;
    cycle();
  endtask

  task automatic test_lone();
    int n;
    do_reset();
    req = 4'b1000;
    cycle();
    n = 0;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (gnt === 4'b1000) n++;
    end
    checks++;
    if (n != 20) begin
      failures++;
      $display("FAIL lone_owner got=%0d exp=20", n);
    end
    req = '0;
    cycle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_reset_mid_grant();
    test_single();
    test_fairness();
    test_handover();
    test_burst();
    test_lone();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
